exe_wb: RTL and testbench

- Back end of the execute pipeline. Consumes the execute-stage result beat, which carries the ALU result, the memory read data, the src_mem_alu select, the destination register address and the write enable.
- Buffers each beat in a 2-entry skid FIFO and drives the register-file write port with a valid/ready handshake.
- Returns dependence information to the decode/execute boundary, as forwarded operands or as a hazard stall, for the three source register addresses that stage presents.

---
 rtl/exe_wb_if.sv | 41 ++++
 rtl/exe_wb.sv | 144 ++++++++++++++
 tb/tb_exe_wb.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_wb_if.sv
// exe_wb_if: execute-beat input and register-file write port bundle.
//   Signals:
//     exe_valid / exe_ready   handshake for the execute result beat
//     exe_alu_result          ALU result
//     exe_mem_data            memory read data
//     exe_src_mem_alu         1 = write back memory data, 0 = ALU result
//     exe_wr_addr, exe_wr_en  destination register and write enable
//     wb_valid / wb_ready     handshake for the register-file write port
//     wb_wr_en, wb_wr_addr, wb_wr_data  register-file write strobe/address/data
//   Modports:
//     master : the producer/consumer environment around the buffer
//     slave  : the exe_wb buffer itself
interface exe_wb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              exe_valid;
   logic              exe_ready;
   logic [DATA_W-1:0] exe_alu_result;
   logic [DATA_W-1:0] exe_mem_data;
   logic              exe_src_mem_alu;
   logic [ADDR_W-1:0] exe_wr_addr;
   logic              exe_wr_en;
   logic              wb_valid;
   logic              wb_ready;
   logic              wb_wr_en;
   logic [ADDR_W-1:0] wb_wr_addr;
   logic [DATA_W-1:0] wb_wr_data;

   modport master (
      output exe_valid, exe_alu_result, exe_mem_data, exe_src_mem_alu,
             exe_wr_addr, exe_wr_en, wb_ready,
      input  exe_ready, wb_valid, wb_wr_en, wb_wr_addr, wb_wr_data
   );

   modport slave (
      input  exe_valid, exe_alu_result, exe_mem_data, exe_src_mem_alu,
             exe_wr_addr, exe_wr_en, wb_ready,
      output exe_ready, wb_valid, wb_wr_en, wb_wr_addr, wb_wr_data
   );
endinterface

// File: rtl/exe_wb.sv
// exe_wb: execute-pipeline back end. Buffers execute result beats in a
// 2-entry skid FIFO, drives the register-file write port, counts retired
// register writes and reports operand dependences to decode.
//   Ports:
//     clk            clock, rising edge
//     rst            asynchronous reset, active-low
//     flush          synchronous flush; empties the FIFO, beats are dropped
//     bus            exe_wb_if.slave: execute beat in, write port out
//     id_regK_addr   source register addresses under decode (K = 1..3)
//     fwd_hitK       forward valid per source
//     fwd_dataK      forwarded value per source
//     hazard_stall   decode must hold
//     retire_cnt     count of completed register writes (wraps)
//   Build option:
//     WB_FORWARD_EN  defined   : matching sources are forwarded, no stall
//                    undefined : no forwarding, any match raises hazard_stall
module exe_wb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   exe_wb_if.slave           bus,
   input  logic [ADDR_W-1:0] id_reg1_addr,
   input  logic [ADDR_W-1:0] id_reg2_addr,
   input  logic [ADDR_W-1:0] id_reg3_addr,
   output logic              fwd_hit1,
   output logic              fwd_hit2,
   output logic              fwd_hit3,
   output logic [DATA_W-1:0] fwd_data1,
   output logic [DATA_W-1:0] fwd_data2,
   output logic [DATA_W-1:0] fwd_data3,
   output logic              hazard_stall,
   output logic [CNT_W-1:0]  retire_cnt
);

   logic [1:0]        cnt_p0;
   logic              head_p0;
   logic              tail_p0;
   logic              ent_wr_en_p0 [2];
   logic [ADDR_W-1:0] ent_addr_p0  [2];
   logic [DATA_W-1:0] ent_data_p0  [2];

   logic              rdy;
   logic              vld;
   logic              push;
   logic              pop;
   logic [1:0]        ent_vld;
   logic [ADDR_W-1:0] src_addr  [3];
   logic [2:0]        match_yng;
   logic [2:0]        match_old;

   assign rdy  = (cnt_p0 != 2'd2);
   assign vld  = (cnt_p0 != 2'd0);
   assign push = bus.exe_valid && rdy && !flush;
   assign pop  = vld && bus.wb_ready && !flush;

   // With count 1 only the head entry is live; with count 2 both are.
   assign ent_vld[0] = cnt_p0[1] | (cnt_p0[0] & ~head_p0);
   assign ent_vld[1] = cnt_p0[1] | (cnt_p0[0] &  head_p0);

   assign bus.exe_ready  = rdy;
   assign bus.wb_valid   = vld;
   assign bus.wb_wr_en   = vld && ent_wr_en_p0[head_p0];
   // Gated so the port reads zero while empty (entry storage is not reset).
   assign bus.wb_wr_addr = vld ? ent_addr_p0[head_p0] : '0;
   assign bus.wb_wr_data = vld ? ent_data_p0[head_p0] : '0;

   // ---- stage p0: FIFO control and retire counter ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_p0     <= 2'd0;
         head_p0    <= 1'b0;
         tail_p0    <= 1'b0;
         retire_cnt <= '0;
      end else if (flush) begin
         cnt_p0  <= 2'd0;
         head_p0 <= 1'b0;
         tail_p0 <= 1'b0;
      end else begin
         if (push) tail_p0 <= ~tail_p0;
         if (pop)  head_p0 <= ~head_p0;
         case ({push, pop})
            2'b10:   cnt_p0 <= cnt_p0 + 2'd1;
            2'b01:   cnt_p0 <= cnt_p0 - 2'd1;
            default: cnt_p0 <= cnt_p0;
         endcase
         if (pop && ent_wr_en_p0[head_p0])
            retire_cnt <= retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // ---- stage p0: entry payload, write-back data chosen at push time ----
   always_ff @(posedge clk) begin
      if (push) begin
         ent_wr_en_p0[tail_p0] <= bus.exe_wr_en;
         ent_addr_p0[tail_p0]  <= bus.exe_wr_addr;
         ent_data_p0[tail_p0]  <= bus.exe_src_mem_alu ? bus.exe_mem_data
                                                      : bus.exe_alu_result;
      end
   end

   assign src_addr[0] = id_reg1_addr;
   assign src_addr[1] = id_reg2_addr;
   assign src_addr[2] = id_reg3_addr;

   // The youngest entry always sits at tail-1; the other slot is older.
   always_comb begin
      match_yng = '0;
      match_old = '0;
      for (int k = 0; k < 3; k++) begin
         match_yng[k] = ent_vld[~tail_p0] && ent_wr_en_p0[~tail_p0] &&
                        (ent_addr_p0[~tail_p0] == src_addr[k]);
         match_old[k] = ent_vld[tail_p0] && ent_wr_en_p0[tail_p0] &&
                        (ent_addr_p0[tail_p0] == src_addr[k]);
      end
   end

`ifdef WB_FORWARD_EN
   logic [DATA_W-1:0] data_yng;
   logic [DATA_W-1:0] data_old;

   assign data_yng     = ent_data_p0[~tail_p0];
   assign data_old     = ent_data_p0[tail_p0];
   assign fwd_hit1     = match_yng[0] | match_old[0];
   assign fwd_hit2     = match_yng[1] | match_old[1];
   assign fwd_hit3     = match_yng[2] | match_old[2];
   assign fwd_data1    = match_yng[0] ? data_yng : data_old;
   assign fwd_data2    = match_yng[1] ? data_yng : data_old;
   assign fwd_data3    = match_yng[2] ? data_yng : data_old;
   assign hazard_stall = 1'b0;
`else
   assign fwd_hit1     = 1'b0;
   assign fwd_hit2     = 1'b0;
   assign fwd_hit3     = 1'b0;
   assign fwd_data1    = '0;
   assign fwd_data2    = '0;
   assign fwd_data3    = '0;
   assign hazard_stall = |(match_yng | match_old);
`endif

endmodule

// File: tb/tb_exe_wb.sv
module tb_exe_wb;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;

   logic          clk;
   logic          rst;
   logic          flush;
   logic [AW-1:0] id1, id2, id3;
   logic          hit1, hit2, hit3;
   logic [DW-1:0] fd1, fd2, fd3;
   logic          hz;
   logic [CW-1:0] ret;

   exe_wb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   exe_wb #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus),
      .id_reg1_addr(id1), .id_reg2_addr(id2), .id_reg3_addr(id3),
      .fwd_hit1(hit1), .fwd_hit2(hit2), .fwd_hit3(hit3),
      .fwd_data1(fd1), .fwd_data2(fd2), .fwd_data3(fd3),
      .hazard_stall(hz), .retire_cnt(ret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic drive(input logic f, input logic ev, input logic src,
                        input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                        input logic [AW-1:0] a, input logic wen, input logic wr);
      flush               = f;
      bus.exe_valid       = ev;
      bus.exe_src_mem_alu = src;
      bus.exe_alu_result  = alu;
      bus.exe_mem_data    = mem;
      bus.exe_wr_addr     = a;
      bus.exe_wr_en       = wen;
      bus.wb_ready        = wr;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic          f, ev, src;
      logic [DW-1:0] alu, mem;
      logic [AW-1:0] a;
      logic          wen, wr;
      logic          e_rdy, e_vld, e_wen;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_data;
      logic [CW-1:0] e_ret;
   } vec_t;

   vec_t tbl [12];

   typedef struct {
      logic          wen;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          q[$];
   logic [CW-1:0] m_ret;

   // Reference lookup: newest buffered writer of the address wins.
   task automatic m_lookup(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
      h = 1'b0;
      d = '0;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (!h && q[i].wen && q[i].a == a) begin
            h = 1'b1;
            d = q[i].d;
         end
      end
   endtask

   task automatic chk_src(input string nm, input logic [AW-1:0] a,
                          input logic h_act, input logic [DW-1:0] d_act);
      logic          h;
      logic [DW-1:0] d;
      m_lookup(a, h, d);
`ifdef WB_FORWARD_EN
      chk({nm, "_hit"}, {63'd0, h_act}, {63'd0, h});
      if (h) chk({nm, "_data"}, {32'd0, d_act}, {32'd0, d});
`else
      chk({nm, "_hit"}, {63'd0, h_act}, 64'd0);
      chk({nm, "_data"}, {32'd0, d_act}, 64'd0);
`endif
   endtask

   initial begin
      logic h1, h2, h3;
      logic [DW-1:0] dd;
      logic push, pop, ev_r, wr_r, f_r;

      tbl[0]  = '{1'b0,1'b1,1'b1,32'h5,32'hDEADBEEF,5'd7,1'b1,1'b1, 1'b1,1'b0,1'b0,5'd0,32'h0,4'd0};
      tbl[1]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,5'd0,1'b0,1'b1, 1'b1,1'b1,1'b1,5'd7,32'hDEADBEEF,4'd0};
      tbl[2]  = '{1'b0,1'b1,1'b0,32'hA1,32'h0,5'd1,1'b1,1'b0, 1'b1,1'b0,1'b0,5'd0,32'h0,4'd1};
      tbl[3]  = '{1'b0,1'b1,1'b0,32'hB2,32'h0,5'd2,1'b1,1'b0, 1'b1,1'b1,1'b1,5'd1,32'hA1,4'd1};
      tbl[4]  = '{1'b0,1'b1,1'b0,32'hC3,32'h0,5'd3,1'b1,1'b0, 1'b0,1'b1,1'b1,5'd1,32'hA1,4'd1};
      tbl[5]  = '{1'b0,1'b1,1'b0,32'hC3,32'h0,5'd3,1'b1,1'b1, 1'b0,1'b1,1'b1,5'd1,32'hA1,4'd1};
      tbl[6]  = '{1'b0,1'b1,1'b0,32'hC3,32'h0,5'd3,1'b1,1'b1, 1'b1,1'b1,1'b1,5'd2,32'hB2,4'd2};
      tbl[7]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,5'd0,1'b0,1'b1, 1'b1,1'b1,1'b1,5'd3,32'hC3,4'd3};
      tbl[8]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,5'd0,1'b0,1'b0, 1'b1,1'b0,1'b0,5'd0,32'h0,4'd4};
      tbl[9]  = '{1'b0,1'b1,1'b0,32'h99,32'h0,5'd9,1'b0,1'b0, 1'b1,1'b0,1'b0,5'd0,32'h0,4'd4};
      tbl[10] = '{1'b0,1'b0,1'b0,32'h0,32'h0,5'd0,1'b0,1'b1, 1'b1,1'b1,1'b0,5'd9,32'h99,4'd4};
      tbl[11] = '{1'b0,1'b0,1'b0,32'h0,32'h0,5'd0,1'b0,1'b0, 1'b1,1'b0,1'b0,5'd0,32'h0,4'd4};

      id1 = 5'd31; id2 = 5'd30; id3 = 5'd29;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      #2;
      chk("rst_exe_ready", {63'd0, bus.exe_ready}, 64'd1);
      chk("rst_wb_valid", {63'd0, bus.wb_valid}, 64'd0);
      chk("rst_retire", {60'd0, ret}, 64'd0);
      chk("rst_wb_addr_data", {27'd0, bus.wb_wr_addr, bus.wb_wr_data}, 64'd0);
      next_cycle(); next_cycle();
      rst = 1'b1;
      next_cycle();

      // Table: single beat, backpressure A/B/C, non-writing beat.
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].f, tbl[i].ev, tbl[i].src, tbl[i].alu, tbl[i].mem,
               tbl[i].a, tbl[i].wen, tbl[i].wr);
         #3;
         chk($sformatf("t%0d_exe_ready", i), {63'd0, bus.exe_ready}, {63'd0, tbl[i].e_rdy});
         chk($sformatf("t%0d_wb_valid", i), {63'd0, bus.wb_valid}, {63'd0, tbl[i].e_vld});
         chk($sformatf("t%0d_wb_wr_en", i), {63'd0, bus.wb_wr_en}, {63'd0, tbl[i].e_wen});
         chk($sformatf("t%0d_wb_addr", i), {59'd0, bus.wb_wr_addr}, {59'd0, tbl[i].e_addr});
         chk($sformatf("t%0d_wb_data", i), {32'd0, bus.wb_wr_data}, {32'd0, tbl[i].e_data});
         chk($sformatf("t%0d_retire", i), {60'd0, ret}, {60'd0, tbl[i].e_ret});
         next_cycle();
      end

      // Reset while a beat is buffered.
      drive(0, 1, 0, 32'h11, 0, 5'd3, 1, 0);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rmid_pre_valid", {63'd0, bus.wb_valid}, 64'd1);
      rst = 1'b0;
      #1;
      chk("rmid_wb_valid", {63'd0, bus.wb_valid}, 64'd0);
      chk("rmid_retire", {60'd0, ret}, 64'd0);
      chk("rmid_exe_ready", {63'd0, bus.exe_ready}, 64'd1);
      chk("rmid_wr_en", {63'd0, bus.wb_wr_en}, 64'd0);
      next_cycle();
      rst = 1'b1;
      bus.wb_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #3;
         chk("rmid_post_wr_en", {63'd0, bus.wb_wr_en}, 64'd0);
         chk("rmid_post_retire", {60'd0, ret}, 64'd0);
         next_cycle();
      end

      // Streaming: push and pop every cycle at count 1.
      for (int i = 0; i <= 10; i++) begin
         drive(0, (i < 10), 0, 32'h100 + i, 32'hFFFF, AW'(i + 1), 1, 1);
         #3;
         if (i == 0) begin
            chk("strm_first_valid", {63'd0, bus.wb_valid}, 64'd0);
         end else begin
            chk($sformatf("strm%0d_valid", i), {63'd0, bus.wb_valid}, 64'd1);
            chk($sformatf("strm%0d_ready", i), {63'd0, bus.exe_ready}, 64'd1);
            chk($sformatf("strm%0d_wr_en", i), {63'd0, bus.wb_wr_en}, 64'd1);
            chk($sformatf("strm%0d_addr", i), {59'd0, bus.wb_wr_addr}, 64'(i));
            chk($sformatf("strm%0d_data", i), {32'd0, bus.wb_wr_data}, 64'(32'h100 + i - 1));
         end
         next_cycle();
      end
      #3;
      chk("strm_end_valid", {63'd0, bus.wb_valid}, 64'd0);
      chk("strm_retire", {60'd0, ret}, 64'd10);
      next_cycle();

      // Two buffered writers of r4, younger must win.
      drive(0, 1, 0, 32'h1, 0, 5'd4, 1, 0);
      next_cycle();
      drive(0, 1, 0, 32'h2, 0, 5'd4, 1, 0);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      id1 = 5'd5; id2 = 5'd4; id3 = 5'd0;
      #3;
`ifdef WB_FORWARD_EN
      chk("fwd_hit2", {63'd0, hit2}, 64'd1);
      chk("fwd_data2", {32'd0, fd2}, 64'h2);
      chk("fwd_hazard", {63'd0, hz}, 64'd0);
      chk("fwd_hit1", {63'd0, hit1}, 64'd0);
      chk("fwd_hit3", {63'd0, hit3}, 64'd0);
`else
      chk("nofwd_hazard", {63'd0, hz}, 64'd1);
      chk("nofwd_hit2", {63'd0, hit2}, 64'd0);
      chk("nofwd_data2", {32'd0, fd2}, 64'd0);
`endif
      chk("fwd_full_ready", {63'd0, bus.exe_ready}, 64'd0);

      // Flush at count 2 with a push and a ready write port.
      drive(1, 1, 0, 32'h66, 0, 5'd6, 1, 1);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      #3;
      chk("flush_wb_valid", {63'd0, bus.wb_valid}, 64'd0);
      chk("flush_exe_ready", {63'd0, bus.exe_ready}, 64'd1);
      chk("flush_retire", {60'd0, ret}, 64'd10);
      chk("flush_hazard", {63'd0, hz}, 64'd0);
      next_cycle();
      #3;
      chk("flush_dropped", {63'd0, bus.wb_valid}, 64'd0);
      next_cycle();

      // Randomised run against the queue model.
      rst = 1'b0;
      next_cycle();
      rst = 1'b1;
      q.delete();
      m_ret = '0;
      for (int c = 0; c < 600; c++) begin
         f_r  = ($urandom_range(0, 15) == 0);
         ev_r = ($urandom_range(0, 3) != 0);
         wr_r = ($urandom_range(0, 2) != 0);
         drive(f_r, ev_r, 1'($urandom_range(0, 1)), $urandom, $urandom,
               AW'($urandom_range(0, 3)), ($urandom_range(0, 4) != 0), wr_r);
         id1 = AW'($urandom_range(0, 3));
         id2 = AW'($urandom_range(0, 3));
         id3 = AW'($urandom_range(0, 3));
         #3;
         chk("rnd_exe_ready", {63'd0, bus.exe_ready}, {63'd0, q.size() < 2});
         chk("rnd_wb_valid", {63'd0, bus.wb_valid}, {63'd0, q.size() > 0});
         if (q.size() > 0) begin
            chk("rnd_wr_en", {63'd0, bus.wb_wr_en}, {63'd0, q[0].wen});
            chk("rnd_addr", {59'd0, bus.wb_wr_addr}, {59'd0, q[0].a});
            chk("rnd_data", {32'd0, bus.wb_wr_data}, {32'd0, q[0].d});
         end else begin
            chk("rnd_empty_wr_en", {63'd0, bus.wb_wr_en}, 64'd0);
         end
         chk("rnd_retire", {60'd0, ret}, {60'd0, m_ret});
         chk_src("rnd_src1", id1, hit1, fd1);
         chk_src("rnd_src2", id2, hit2, fd2);
         chk_src("rnd_src3", id3, hit3, fd3);
         m_lookup(id1, h1, dd);
         m_lookup(id2, h2, dd);
         m_lookup(id3, h3, dd);
`ifdef WB_FORWARD_EN
         chk("rnd_hazard", {63'd0, hz}, 64'd0);
`else
         chk("rnd_hazard", {63'd0, hz}, {63'd0, h1 | h2 | h3});
`endif
         push = ev_r && (q.size() < 2) && !f_r;
         pop  = wr_r && (q.size() > 0) && !f_r;
         @(posedge clk);
         if (f_r) begin
            q.delete();
         end else begin
            if (pop) begin
               if (q[0].wen) m_ret = m_ret + 1'b1;
               void'(q.pop_front());
            end
            if (push)
               q.push_back('{bus.exe_wr_en, bus.exe_wr_addr,
                             bus.exe_src_mem_alu ? bus.exe_mem_data : bus.exe_alu_result});
         end
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
